// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the shared 16-bit FPU: latches one request, holds operands
// for LATENCY cycles, then emits a single-cycle writeback and counts completed ops.
module fpu_issue_ctrl #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   input  logic [15:0]      req_a,
   input  logic [15:0]      req_b,
   input  logic [3:0]       req_dest,
   output logic             req_ready,
   input  logic             flush,
   output logic [15:0]      fpu_opA,
   output logic [15:0]      fpu_opB,
   output logic [1:0]       fpu_op,
   input  logic [15:0]      fpu_result,
   input  logic [3:0]       fpu_flags,
   output logic             wb_valid,
   output logic [15:0]      wb_data,
   output logic [3:0]       wb_addr,
   output logic [3:0]       wb_flags,
   output logic             stall,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [3:0] dest_q;
   logic       accept;

   assign req_ready = (state == IDLE || state == WB) && !flush && !reset;
   assign accept    = req_valid && req_ready;
   // The accepting cycle also stalls so fetch does not re-issue the instruction.
   assign stall     = (state == EXEC) || accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dest_q   <= '0;
         fpu_opA  <= '0;
         fpu_opB  <= '0;
         fpu_op   <= '0;
         wb_data  <= '0;
         wb_addr  <= '0;
         wb_flags <= '0;
         wb_valid <= 1'b0;
         busy     <= 1'b0;
         ops_done <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE, WB: begin
               if (state == WB)
                  ops_done <= ops_done + 1'b1;
               if (accept) begin
                  fpu_opA <= req_a;
                  fpu_opB <= req_b;
                  fpu_op  <= req_op;
                  dest_q  <= req_dest;
                  cnt     <= CNT_INIT;
                  state   <= EXEC;
                  busy    <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            EXEC: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  wb_data  <= fpu_result;
                  wb_flags <= fpu_flags;
                  wb_addr  <= dest_q;
                  wb_valid <= 1'b1;
                  busy     <= 1'b0;
                  state    <= WB;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: three parameterisations share one directed stimulus and are
// checked each cycle against a cycles-since-accept model, plus literal expectations.
module tb_fpu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset, flush, req_valid;
   logic [1:0]  req_op;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_dest;

   logic        ready [3];
   logic        stl   [3];
   logic        bsy   [3];
   logic        wbv   [3];
   logic [15:0] opa   [3];
   logic [15:0] opb   [3];
   logic [1:0]  opc   [3];
   logic [15:0] res   [3];
   logic [3:0]  flg   [3];
   logic [15:0] wbd   [3];
   logic [3:0]  wba   [3];
   logic [3:0]  wbf   [3];
   logic [15:0] done0, done2;
   logic [1:0]  done1;
   logic [15:0] done  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] fpu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] o);
      if (a == 16'h3C00 && b == 16'h4000 && o == 2'd0) return 16'h4200;
      return a + b + 16'(o);
   endfunction

   function automatic logic [3:0] flag_fn(input logic [15:0] r);
      return {r[15], r == 16'h0000, 2'b00};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_fpu
      assign res[g] = fpu_fn(opa[g], opb[g], opc[g]);
      assign flg[g] = flag_fn(res[g]);
   end

   assign done[0] = done0;
   assign done[1] = {14'b0, done1};
   assign done[2] = done2;

   fpu_issue_ctrl #(.LATENCY(2), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
      .req_b(req_b), .req_dest(req_dest), .req_ready(ready[0]), .flush(flush),
      .fpu_opA(opa[0]), .fpu_opB(opb[0]), .fpu_op(opc[0]), .fpu_result(res[0]),
      .fpu_flags(flg[0]), .wb_valid(wbv[0]), .wb_data(wbd[0]), .wb_addr(wba[0]),
      .wb_flags(wbf[0]), .stall(stl[0]), .busy(bsy[0]), .ops_done(done0));

   fpu_issue_ctrl #(.LATENCY(2), .CNT_W(2)) u1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
      .req_b(req_b), .req_dest(req_dest), .req_ready(ready[1]), .flush(flush),
      .fpu_opA(opa[1]), .fpu_opB(opb[1]), .fpu_op(opc[1]), .fpu_result(res[1]),
      .fpu_flags(flg[1]), .wb_valid(wbv[1]), .wb_data(wbd[1]), .wb_addr(wba[1]),
      .wb_flags(wbf[1]), .stall(stl[1]), .busy(bsy[1]), .ops_done(done1));

   fpu_issue_ctrl #(.LATENCY(1), .CNT_W(16)) u2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
      .req_b(req_b), .req_dest(req_dest), .req_ready(ready[2]), .flush(flush),
      .fpu_opA(opa[2]), .fpu_opB(opb[2]), .fpu_op(opc[2]), .fpu_result(res[2]),
      .fpu_flags(flg[2]), .wb_valid(wbv[2]), .wb_data(wbd[2]), .wb_addr(wba[2]),
      .wb_flags(wbf[2]), .stall(stl[2]), .busy(bsy[2]), .ops_done(done2));

   task automatic chk(input string name, input int k, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[u%0d] at %0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   // Model: phase counts cycles since acceptance (1..LAT = EXEC, LAT+1 = WB, 0 = idle).
   int          lat [3] = '{2, 2, 1};
   int          wid [3] = '{16, 2, 16};
   int          phase [3];
   logic [15:0] m_a [3], m_b [3], m_wbd [3];
   logic [1:0]  m_op [3];
   logic [3:0]  m_dest [3], m_wba [3], m_wbf [3];
   longint      m_done [3];
   bit          mvalid = 1'b0;
   bit          ex, wbp, rdy, acc;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         ex  = phase[k] >= 1 && phase[k] <= lat[k];
         wbp = phase[k] == lat[k] + 1;
         rdy = !ex && !flush && !reset;
         acc = rdy && req_valid;
         if (mvalid) begin
            chk("req_ready", k, 16'(ready[k]), 16'(rdy));
            chk("stall",     k, 16'(stl[k]),   16'(ex || acc));
            chk("busy",      k, 16'(bsy[k]),   16'(ex));
            chk("wb_valid",  k, 16'(wbv[k]),   16'(wbp));
            chk("fpu_opA",   k, opa[k],        m_a[k]);
            chk("fpu_opB",   k, opb[k],        m_b[k]);
            chk("fpu_op",    k, 16'(opc[k]),   16'(m_op[k]));
            chk("wb_data",   k, wbd[k],        m_wbd[k]);
            chk("wb_addr",   k, 16'(wba[k]),   16'(m_wba[k]));
            chk("wb_flags",  k, 16'(wbf[k]),   16'(m_wbf[k]));
            chk("ops_done",  k, done[k],       16'(m_done[k]));
         end
         if (reset) begin
            phase[k] = 0; m_a[k] = '0; m_b[k] = '0; m_op[k] = '0; m_dest[k] = '0;
            m_wbd[k] = '0; m_wba[k] = '0; m_wbf[k] = '0; m_done[k] = 0;
         end else begin
            if (wbp) m_done[k] = (m_done[k] + 1) % (longint'(1) << wid[k]);
            if (ex && flush) phase[k] = 0;
            else if (ex && phase[k] == lat[k]) begin
               m_wbd[k] = fpu_fn(m_a[k], m_b[k], m_op[k]);
               m_wbf[k] = flag_fn(m_wbd[k]);
               m_wba[k] = m_dest[k];
               phase[k] = lat[k] + 1;
            end else if (ex) phase[k] = phase[k] + 1;
            else if (acc) begin
               m_a[k] = req_a; m_b[k] = req_b; m_op[k] = req_op; m_dest[k] = req_dest;
               phase[k] = 1;
            end else phase[k] = 0;
         end
      end
      if (reset) mvalid = 1'b1;
   end

   task automatic step(input logic r, input logic f, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] o, input logic [3:0] d);
      @(posedge clk);
      #1;
      reset = r; flush = f; req_valid = v; req_a = a; req_b = b; req_op = o; req_dest = d;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 4'd0);
   endtask

   logic [1:0] wrap_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
      req_a = '0; req_b = '0; req_op = '0; req_dest = '0;
      step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'd0, 4'd0);

      // basic op with operand churn during EXEC
      step(1'b0, 1'b0, 1'b1, 16'h3C00, 16'h4000, 2'd0, 4'd3);
      chk("lit_accept_ready", 0, 16'(ready[0]), 16'd1);
      chk("lit_accept_stall", 0, 16'(stl[0]), 16'd1);
      step(1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 2'd3, 4'd0);
      chk("lit_busy1", 0, 16'(bsy[0]), 16'd1);
      chk("lit_opA1", 0, opa[0], 16'h3C00);
      chk("lit_opB1", 0, opb[0], 16'h4000);
      step(1'b0, 1'b0, 1'b0, 16'h5555, 16'h6666, 2'd1, 4'd0);
      chk("lit_busy2", 0, 16'(bsy[0]), 16'd1);
      chk("lit_opA2", 0, opa[0], 16'h3C00);
      chk("lit_opB2", 0, opb[0], 16'h4000);

      // WB of first op, second request accepted back-to-back
      step(1'b0, 1'b0, 1'b1, 16'h4000, 16'h4000, 2'd2, 4'd5);
      chk("lit_wbv1", 0, 16'(wbv[0]), 16'd1);
      chk("lit_wbdata1", 0, wbd[0], 16'h4200);
      chk("lit_wbaddr1", 0, 16'(wba[0]), 16'd3);
      chk("lit_wbflags1", 0, 16'(wbf[0]), 16'd0);
      chk("lit_b2b_ready", 0, 16'(ready[0]), 16'd1);
      idle();
      chk("lit_done1", 0, done[0], 16'd1);
      chk("lit_wbv_off", 0, 16'(wbv[0]), 16'd0);
      chk("lit_b2b_busy", 0, 16'(bsy[0]), 16'd1);
      idle();
      idle();
      chk("lit_wbv2", 0, 16'(wbv[0]), 16'd1);
      chk("lit_wbaddr2", 0, 16'(wba[0]), 16'd5);

      // flush in first EXEC cycle
      step(1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002, 2'd1, 4'd7);
      chk("lit_done2", 0, done[0], 16'd2);
      step(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002, 2'd1, 4'd7);
      chk("lit_flush_busy", 0, 16'(bsy[0]), 16'd1);
      chk("lit_flush_ready", 0, 16'(ready[0]), 16'd0);
      idle();
      chk("lit_postflush_busy", 0, 16'(bsy[0]), 16'd0);
      chk("lit_postflush_wbv", 0, 16'(wbv[0]), 16'd0);
      chk("lit_postflush_stall", 0, 16'(stl[0]), 16'd0);
      chk("lit_postflush_done", 0, done[0], 16'd2);

      // reset in the second EXEC cycle, alongside flush and req_valid
      step(1'b0, 1'b0, 1'b1, 16'h0003, 16'h0004, 2'd0, 4'd9);
      idle();
      step(1'b1, 1'b1, 1'b1, 16'h0005, 16'h0006, 2'd0, 4'd9);
      chk("lit_rst_ready", 0, 16'(ready[0]), 16'd0);
      idle();
      chk("lit_rst_busy", 0, 16'(bsy[0]), 16'd0);
      chk("lit_rst_wbv", 0, 16'(wbv[0]), 16'd0);
      chk("lit_rst_wbdata", 0, wbd[0], 16'd0);
      chk("lit_rst_wbaddr", 0, 16'(wba[0]), 16'd0);
      chk("lit_rst_opA", 0, opa[0], 16'd0);
      chk("lit_rst_done", 0, done[0], 16'd0);
      chk("lit_rst_ready1", 0, 16'(ready[0]), 16'd1);
      idle();
      idle();

      // four ops: CNT_W=2 wrap on u1, LATENCY=1 timing on u2
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 16'(i * 3), 16'(i + 1), 2'(i), 4'(i + 1));
         chk("lit_loop_ready0", 0, 16'(ready[0]), 16'd1);
         chk("lit_loop_ready2", 2, 16'(ready[2]), 16'd1);
         idle();
         chk("lit_l1_busy", 2, 16'(bsy[2]), 16'd1);
         idle();
         chk("lit_l1_wbv", 2, 16'(wbv[2]), 16'd1);
         chk("lit_l1_busy_off", 2, 16'(bsy[2]), 16'd0);
         idle();
         chk("lit_l2_wbv", 0, 16'(wbv[0]), 16'd1);
         idle();
         chk("lit_wrap_done", 1, 16'(done1), 16'(wrap_exp[i]));
      end
      idle();
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
